// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : input_debouncer
//  Purpose  : 2-flop synchronizer plus counter-qualified debounce FSM that
//             turns a raw bouncy input into a clean registered level.
//             Optional abort counter: define DEBOUNCE_GLITCH_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module input_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1),
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                din,
  output logic                dout,
  output logic                busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  // Elaboration-time parameter sanity checks
  if ((STABLE_CYCLES < 2) || (STABLE_CYCLES > 65535)) begin : g_bad_stable_cycles
    $error("input_debouncer: STABLE_CYCLES must be in 2..65535");
  end
  if (CNT_W != $clog2(STABLE_CYCLES + 1)) begin : g_bad_cnt_w
    $error("input_debouncer: CNT_W is derived and must not be overridden");
  end
  if (GLITCH_W < 1) begin : g_bad_glitch_w
    $error("input_debouncer: GLITCH_W must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    ST_CHK_H = 2'd1,
    ST_HIGH  = 2'd2,
    ST_CHK_L = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             w_din_s;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_dout;
  logic             r_busy;
  logic             w_dout_nxt;
  logic             w_busy_nxt;

  // Plain two-flop synchronizer; nothing may sit between the stages
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  assign w_din_s = r_sync2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_LOW;
      r_cnt   <= C_CNT_ZERO;
      r_dout  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_dout_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // cnt holds the number of qualifying samples already seen for a candidate
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_LOW: begin
        if (w_din_s) begin
          w_state_nxt = ST_CHK_H;
          w_cnt_nxt   = C_CNT_ONE;
        end else begin
          w_cnt_nxt   = C_CNT_ZERO;
        end
      end
      ST_CHK_H: begin
        if (!w_din_s) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = C_CNT_ZERO;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = C_CNT_ZERO;
        end else begin
          w_cnt_nxt   = r_cnt + C_CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!w_din_s) begin
          w_state_nxt = ST_CHK_L;
          w_cnt_nxt   = C_CNT_ONE;
        end else begin
          w_cnt_nxt   = C_CNT_ZERO;
        end
      end
      ST_CHK_L: begin
        if (w_din_s) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = C_CNT_ZERO;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = C_CNT_ZERO;
        end else begin
          w_cnt_nxt   = r_cnt + C_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_LOW;
        w_cnt_nxt   = C_CNT_ZERO;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register with it
  assign w_dout_nxt = (w_state_nxt == ST_HIGH)  || (w_state_nxt == ST_CHK_L);
  assign w_busy_nxt = (w_state_nxt == ST_CHK_H) || (w_state_nxt == ST_CHK_L);

  assign dout = r_dout;
  assign busy = r_busy;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  localparam logic [GLITCH_W-1:0] C_GLITCH_ONE = GLITCH_W'(1);

  logic                w_glitch;
  logic [GLITCH_W-1:0] r_glitch_cnt;

  assign w_glitch = ((r_state == ST_CHK_H) && !w_din_s) ||
                    ((r_state == ST_CHK_L) &&  w_din_s);

  // Saturating abort counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_glitch_cnt <= '0;
    end else if (w_glitch && (r_glitch_cnt != {GLITCH_W{1'b1}})) begin
      r_glitch_cnt <= r_glitch_cnt + C_GLITCH_ONE;
    end
  end

  assign glitch_cnt = r_glitch_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input_debouncer
//  Purpose  : Self-checking bench for input_debouncer: run-length reference
//             model compared every cycle plus directed literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

  localparam int STABLE = 4;

  logic clk;
  logic resetn;
  logic din;
  logic dout;
  logic busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
  logic       sat_dout;
  logic       sat_busy;
  logic [1:0] sat_glitch_cnt;

  input_debouncer #(.STABLE_CYCLES(STABLE), .GLITCH_W(8)) u_dut (
    .clk(clk), .resetn(resetn), .din(din), .dout(dout), .busy(busy),
    .glitch_cnt(glitch_cnt)
  );

  input_debouncer #(.STABLE_CYCLES(STABLE), .GLITCH_W(2)) u_sat (
    .clk(clk), .resetn(resetn), .din(din), .dout(sat_dout), .busy(sat_busy),
    .glitch_cnt(sat_glitch_cnt)
  );
`else
  input_debouncer #(.STABLE_CYCLES(STABLE)) u_dut (
    .clk(clk), .resetn(resetn), .din(din), .dout(dout), .busy(busy)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: din seen through a two-sample delay; dout flips once the
  // delayed input has disagreed with it for STABLE consecutive samples.
  bit m_s1, m_s2, m_dout;
  int m_run;
  int m_glitch;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_dout = 1'b0; m_run = 0; m_glitch = 0;
    end else begin
      if (m_s2 != m_dout) begin
        m_run = m_run + 1;
        if (m_run == STABLE) begin
          m_dout = ~m_dout;
          m_run  = 0;
        end
      end else begin
        if (m_run > 0) m_glitch = m_glitch + 1;
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = din;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_dout", {31'd0, dout}, {31'd0, m_dout});
      chk("model_busy", {31'd0, busy}, {31'd0, (m_run > 0)});
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk("model_glitch", {24'd0, glitch_cnt}, (m_glitch > 255) ? 255 : m_glitch);
      chk("model_glitch_sat", {30'd0, sat_glitch_cnt}, (m_glitch > 3) ? 3 : m_glitch);
      chk("model_sat_dout", {31'd0, sat_dout}, {31'd0, m_dout});
`endif
    end
  end

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int g0;
  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    resetn = 1'b0;
    din    = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset held while din toggles
    for (int i = 0; i < 5; i++) begin
      din = ~din;
      tick(1);
      chk("rst_dout", {31'd0, dout}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk("rst_glitch", {24'd0, glitch_cnt}, 0);
`endif
    end
    din    = 1'b0;
    resetn = 1'b1;
    tick(6);
    chk("rel_dout", {31'd0, dout}, 0);

    // Clean rise then clean fall
    din = 1'b1;
    tick(2);
    chk("rise_busy_e1", {31'd0, busy}, 0);
    tick(1);
    chk("rise_busy_e2", {31'd0, busy}, 1);
    chk("rise_dout_e2", {31'd0, dout}, 0);
    tick(2);
    chk("rise_dout_e4", {31'd0, dout}, 0);
    tick(1);
    chk("rise_dout_e5", {31'd0, dout}, 1);
    chk("rise_busy_e5", {31'd0, busy}, 0);
    din = 1'b0;
    tick(5);
    chk("fall_dout_e4", {31'd0, dout}, 1);
    tick(1);
    chk("fall_dout_e5", {31'd0, dout}, 0);
    tick(3);

    // Bounce then settle high
`ifdef DEBOUNCE_GLITCH_CNT_EN
    g0 = int'(glitch_cnt);
`endif
    for (int i = 0; i < 8; i++) begin
      din = (i % 2 == 0);
      tick(1);
      chk("bounce_dout", {31'd0, dout}, 0);
    end
    din = 1'b1;
    tick(5);
    chk("settle_dout_e4", {31'd0, dout}, 0);
    tick(1);
    chk("settle_dout_e5", {31'd0, dout}, 1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("bounce_glitch_ge3", {31'd0, (int'(glitch_cnt) - g0 >= 3)}, 1);
`endif
    din = 1'b0;
    tick(8);
    chk("back_low", {31'd0, dout}, 0);

    // Short pulse never qualifies
`ifdef DEBOUNCE_GLITCH_CNT_EN
    g0 = int'(glitch_cnt);
`endif
    din = 1'b1;
    tick(3);
    din = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("short_dout", {31'd0, dout}, 0);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("short_glitch_inc", int'(glitch_cnt) - g0, 1);
`endif

    // Asynchronous reset in the middle of a falling qualification
    din = 1'b1;
    tick(8);
    chk("pre_rst_dout", {31'd0, dout}, 1);
    din = 1'b0;
    tick(3);
    chk("chkl_busy", {31'd0, busy}, 1);
    chk("chkl_dout", {31'd0, dout}, 1);
    resetn = 1'b0;
    #1;
    chk("async_dout", {31'd0, dout}, 0);
    chk("async_busy", {31'd0, busy}, 0);
    din    = 1'b1;
    #1;
    resetn = 1'b1;
    tick(5);
    chk("post_rst_dout_e4", {31'd0, dout}, 0);
    tick(1);
    chk("post_rst_dout_e5", {31'd0, dout}, 1);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // Saturation of the narrow counter
    din    = 1'b0;
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(2);
    for (int i = 0; i < 5; i++) begin
      din = 1'b1;
      tick(2);
      din = 1'b0;
      tick(5);
      chk("sat_seq", {30'd0, sat_glitch_cnt}, sat_exp[i]);
    end
`endif

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
